// File: rtl/data_mem_ctrl.sv
// Handshaked data memory for the load/store path: byte-lane stores, extended loads,
// fault reporting, optional post-reset clear sweep. One outstanding request.
module data_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic [1:0]            rsp_fault_code
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;

  logic [31:0]           mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      clr_cnt;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic [1:0]            lane;
  logic                  accept;
  logic                  op_illegal, out_of_range, misaligned, fault;
  logic [1:0]            fault_code;
  logic [31:0]           rd_word, ld_data, st_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [3:0]            st_be;

  assign word_idx = req_addr[ADDR_WIDTH-1:2];
  assign mem_idx  = req_addr[IDX_W+1:2];
  assign lane     = req_addr[1:0];
  assign accept   = req_valid && req_ready;
  assign rd_word  = mem[mem_idx];

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_CLEAR: if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) state_d = S_IDLE;
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = (READ_LATENCY == 2) ? S_WAIT : S_RESP;
      end
      S_WAIT: state_d = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fault priority: illegal op, then out of range, then misaligned
  always_comb begin
    op_illegal   = req_we ? (req_op[2] || req_op == 3'b011)
                          : (req_op == 3'b011 || req_op[2:1] == 2'b11);
    out_of_range = word_idx >= (ADDR_WIDTH-2)'(DEPTH_WORDS);
    misaligned   = 1'b0;
    case (req_op[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = lane != 2'b00;
      default: misaligned = 1'b0;
    endcase
    fault_code = 2'b00;
    if (op_illegal)        fault_code = 2'b11;
    else if (out_of_range) fault_code = 2'b10;
    else if (misaligned)   fault_code = 2'b01;
    fault = fault_code != 2'b00;
  end

  always_comb begin
    ld_byte = 8'(rd_word >> {lane, 3'b000});
    ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = '0;
    case (req_op)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      3'b010:  ld_data = rd_word;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = req_wdata;
    case (req_op[1:0])
      2'b00: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = req_wdata;
      end
    endcase
  end

  // RAM has no reset; a reset edge suppresses any write so in-flight stores are dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (accept && req_we && !fault) begin
        for (int unsigned b = 0; b < 4; b++)
          if (st_be[b]) mem[mem_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt        <= '0;
      rsp_rdata      <= '0;
      rsp_fault      <= 1'b0;
      rsp_fault_code <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept) begin
        rsp_rdata      <= (fault || req_we) ? '0 : ld_data;
        rsp_fault      <= fault;
        rsp_fault_code <= fault_code;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised bench for data_mem_ctrl against a byte-array reference model,
// with a per-cycle compare process and directed literal checks.
module tb_data_mem_ctrl;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned RL    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [2:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready, rsp_valid, rsp_fault;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_fault_code;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .READ_LATENCY(RL), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .rsp_fault_code(rsp_fault_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mbytes [DEPTH*4];
  logic        chk_en = 1'b0;
  logic        exp_req_ready = 1'b0, exp_rsp_valid = 1'b0, exp_fault = 1'b0;
  logic [1:0]  exp_code = '0;
  logic [31:0] exp_rdata = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp_req_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      if (exp_rsp_valid) begin
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
        check("rsp_fault_code", 32'(rsp_fault_code), 32'(exp_code));
      end
    end
  end

  // Memory viewed as a flat little-endian byte array
  task automatic model_access(input logic we, input logic [2:0] op, input logic [AW-1:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic f, output logic [1:0] code);
    int unsigned size, a;
    logic        ill;
    logic [31:0] v;
    size  = 1 << op[1:0];
    a     = addr;
    ill   = we ? (op >= 3'd4 || op == 3'd3) : (op == 3'd3 || op >= 3'd6);
    rdata = '0;
    if (ill)                 code = 2'd3;
    else if (a / 4 >= DEPTH) code = 2'd2;
    else if (a % size != 0)  code = 2'd1;
    else                     code = 2'd0;
    f = code != 2'd0;
    if (!f) begin
      if (we) begin
        for (int i = 0; i < int'(size); i++) mbytes[a+i] = 8'(wdata >> (8*i));
      end else begin
        v = '0;
        for (int i = 0; i < int'(size); i++) v |= 32'(mbytes[a+i]) << (8*i);
        if (!op[2] && size < 4 && v[8*size-1]) v |= 32'hFFFF_FFFF << (8*size);
        rdata = v;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] op, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input int hold, input bit abort,
                        output logic [31:0] got, output logic [1:0] got_code);
    logic [31:0] r;
    logic        f;
    logic [1:0]  c;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    model_access(we, op, addr, wdata, r, f, c);
    @(posedge clk); #1;
    exp_req_ready = 1'b0; exp_rsp_valid = 1'b0;
    exp_rdata = r; exp_fault = f; exp_code = c;
    // keep a pending request visible: it must not be taken before the response handshake
    req_we = 1'($urandom); req_op = 3'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
    repeat (RL - 1) @(posedge clk);
    #1;
    exp_rsp_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    got = rsp_rdata;
    got_code = rsp_fault_code;
    if (abort) return;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    exp_rsp_valid = 1'b0; exp_req_ready = 1'b1;
  endtask

  task automatic do_reset(input int cut);
    int cnt;
    chk_en = 1'b0;
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    check("rst_fault_code", 32'(rsp_fault_code), 32'd0);
    if (cut > 0) begin
      repeat (cut) @(posedge clk);
      #1;
      check("midclear_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rerst_req_ready", 32'(req_ready), 32'd0);
      check("rerst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    cnt = 0;
    while (!req_ready && cnt < 4 * DEPTH) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("clear_cycles", 32'(cnt), 32'(DEPTH));
    for (int i = 0; i < DEPTH * 4; i++) mbytes[i] = 8'h00;
    exp_req_ready = 1'b1; exp_rsp_valid = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    logic [31:0]   got;
    logic [1:0]    gc;
    logic          we;
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [2:0]    ld_ops [5];
    ld_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    do_reset(0);
    do_req(1'b0, 3'd2, 16'h3C, 32'h0, 0, 1'b0, got, gc);  check("lw_cleared", got, 32'h0);
    do_req(1'b1, 3'd2, 16'h08, 32'h8899AABB, 0, 1'b0, got, gc);
    do_req(1'b0, 3'd0, 16'h09, 32'h0, 0, 1'b0, got, gc);  check("lb", got, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 16'h09, 32'h0, 1, 1'b0, got, gc);  check("lbu", got, 32'h000000AA);
    do_req(1'b0, 3'd1, 16'h0A, 32'h0, 0, 1'b0, got, gc);  check("lh", got, 32'hFFFF8899);
    do_req(1'b0, 3'd5, 16'h0A, 32'h0, 2, 1'b0, got, gc);  check("lhu", got, 32'h00008899);
    do_req(1'b0, 3'd2, 16'h08, 32'h0, 0, 1'b0, got, gc);  check("lw", got, 32'h8899AABB);
    do_req(1'b1, 3'd0, 16'h0B, 32'h11, 0, 1'b0, got, gc);
    do_req(1'b1, 3'd1, 16'h08, 32'h2233, 0, 1'b0, got, gc);
    do_req(1'b0, 3'd2, 16'h08, 32'h0, 0, 1'b0, got, gc);  check("lw_merged", got, 32'h11992233);
    do_req(1'b0, 3'd1, 16'h05, 32'h0, 0, 1'b0, got, gc);
    check("lh_mis_code", 32'(gc), 32'd1); check("lh_mis_data", got, 32'h0);
    do_req(1'b1, 3'd2, 16'h04, 32'hCAFEF00D, 0, 1'b0, got, gc);
    do_req(1'b1, 3'd2, 16'h06, 32'h12345678, 0, 1'b0, got, gc); check("sw_mis_code", 32'(gc), 32'd1);
    do_req(1'b0, 3'd2, 16'h04, 32'h0, 0, 1'b0, got, gc);  check("sw_mis_nowrite", got, 32'hCAFEF00D);
    do_req(1'b0, 3'd2, 16'h40, 32'h0, 0, 1'b0, got, gc);  check("oor_code", 32'(gc), 32'd2);
    do_req(1'b0, 3'd3, 16'h00, 32'h0, 0, 1'b0, got, gc);  check("ill_load_code", 32'(gc), 32'd3);
    do_req(1'b1, 3'd4, 16'h41, 32'h0, 0, 1'b0, got, gc);  check("ill_store_code", 32'(gc), 32'd3);
    do_req(1'b0, 3'd2, 16'h08, 32'h0, 5, 1'b0, got, gc);  check("lw_held", got, 32'h11992233);

    do_req(1'b1, 3'd2, 16'h00, 32'h12345678, 2, 1'b1, got, gc);
    do_reset(0);
    do_req(1'b0, 3'd2, 16'h08, 32'h0, 0, 1'b0, got, gc);  check("lw_after_rst", got, 32'h0);
    do_req(1'b1, 3'd2, 16'h0C, 32'hDEADBEEF, 0, 1'b0, got, gc);
    do_reset(5);
    do_req(1'b0, 3'd2, 16'h0C, 32'h0, 0, 1'b0, got, gc);  check("lw_after_reclear", got, 32'h0);

    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) == 0) op = 3'($urandom);
      else if (we)                   op = 3'($urandom_range(0, 2));
      else                           op = ld_ops[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) addr = AW'($urandom_range(0, 255));
      else                           addr = AW'($urandom_range(0, DEPTH * 4 - 1));
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      do_req(we, op, addr, $urandom, $urandom_range(0, 3), 1'b0, got, gc);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
